// File: rtl/inst_decode_queue.sv
// Instruction buffer with MIPS32 main decoder on enqueue and trap serialisation.
// Optional feature macro: RELU_INST_EN (custom relu encoding op 6'b011100, funct 6'b000000).
module inst_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [PC_W-1:0] i_in_pc,
    input  logic [31:0]     i_in_instr,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [PC_W-1:0] o_out_pc,
    output logic [31:0]     o_out_instr,
    output logic [20:0]     o_out_ctrl
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    localparam int B_REGWRITE = 20;
    localparam int B_REGDST   = 19;
    localparam int B_ALUSRC   = 18;
    localparam int B_BRANCH   = 17;
    localparam int B_MEMTOREG = 12;
    localparam int B_JUMP     = 11;
    localparam int B_JAL      = 10;
    localparam int B_JR       = 9;
    localparam int B_BAL      = 8;
    localparam int B_MEMEN    = 7;
    localparam int B_HILO     = 6;
    localparam int B_BREAK    = 5;
    localparam int B_SYSCALL  = 4;
    localparam int B_RESERVE  = 3;
    localparam int B_ERET     = 2;
    localparam int B_CP0WE    = 1;
    localparam int B_CP0SEL   = 0;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic logic [20:0] f_decode(input logic [31:0] instr);
        logic [20:0] c;
        c = 21'd0;
        case (instr[31:26])
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                c[B_REGWRITE] = 1'b1;
                c[B_ALUSRC]   = 1'b1;
            end
            6'h02: c[B_JUMP] = 1'b1;
            6'h03: begin
                c[B_REGWRITE] = 1'b1;
                c[B_JAL]      = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: c[B_BRANCH] = 1'b1;
            6'h01: begin
                case (instr[20:16])
                    5'b00000, 5'b00001: c[B_BRANCH] = 1'b1;
                    5'b10000, 5'b10001: begin
                        c[B_REGWRITE] = 1'b1;
                        c[B_BRANCH]   = 1'b1;
                        c[B_BAL]      = 1'b1;
                    end
                    default: c[B_RESERVE] = 1'b1;
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                c[B_REGWRITE] = 1'b1;
                c[B_ALUSRC]   = 1'b1;
                c[B_MEMTOREG] = 1'b1;
                c[B_MEMEN]    = 1'b1;
            end
            6'h28, 6'h29, 6'h2B: begin
                c[B_ALUSRC] = 1'b1;
                c[B_MEMEN]  = 1'b1;
                case (instr[27:26])
                    2'b00:   c[16:13] = 4'b0001;
                    2'b01:   c[16:13] = 4'b0011;
                    default: c[16:13] = 4'b1111;
                endcase
            end
            6'h00: begin
                case (instr[5:0])
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: c[B_HILO] = 1'b1;
                    6'h10, 6'h12: begin
                        c[B_REGWRITE] = 1'b1;
                        c[B_REGDST]   = 1'b1;
                        c[B_HILO]     = 1'b1;
                    end
                    6'h08: c[B_JR] = 1'b1;
                    6'h09: begin
                        c[B_REGWRITE] = 1'b1;
                        c[B_REGDST]   = 1'b1;
                        c[B_JR]       = 1'b1;
                    end
                    6'h0D: c[B_BREAK]   = 1'b1;
                    6'h0C: c[B_SYSCALL] = 1'b1;
                    default: begin
                        c[B_REGWRITE] = 1'b1;
                        c[B_REGDST]   = 1'b1;
                    end
                endcase
            end
            6'h10: begin
                if (instr == 32'h4200_0018) begin
                    c[B_ERET] = 1'b1;
                end else if (instr[25:21] == 5'b00100 && instr[10:3] == 8'd0) begin
                    c[B_CP0WE] = 1'b1;
                end else if (instr[25:21] == 5'b00000 && instr[10:3] == 8'd0) begin
                    c[B_REGWRITE] = 1'b1;
                    c[B_CP0SEL]   = 1'b1;
                end else begin
                    c[B_RESERVE] = 1'b1;
                end
            end
`ifdef RELU_INST_EN
            6'h1C: begin
                if (instr[5:0] == 6'h00) begin
                    c[B_REGWRITE] = 1'b1;
                    c[B_REGDST]   = 1'b1;
                end else begin
                    c[B_RESERVE] = 1'b1;
                end
            end
`endif
            default: c[B_RESERVE] = 1'b1;
        endcase
        return c;
    endfunction

    logic [PC_W-1:0] r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_instr [DEPTH];
    logic [20:0]     r_mem_ctrl  [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    state_e          r_state;
    state_e          w_state_nxt;
    logic            w_out_valid;
    logic            w_enq;
    logic            w_deq;
    logic [20:0]     w_head_ctrl;
    logic            w_head_trap;

    assign o_in_ready  = (r_count != C_FULL) && !i_rst && !i_flush;
    assign w_enq       = i_in_valid && o_in_ready;
    assign w_deq       = w_out_valid && i_out_ready;
    assign w_head_ctrl = r_mem_ctrl[r_rd_ptr];
    assign w_head_trap = w_head_ctrl[B_BREAK] | w_head_ctrl[B_SYSCALL] |
                         w_head_ctrl[B_RESERVE] | w_head_ctrl[B_ERET];

    // Entry storage; contents need no reset because outputs are gated by out_valid.
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_mem_pc[r_wr_ptr]    <= i_in_pc;
            r_mem_instr[r_wr_ptr] <= i_in_instr;
            r_mem_ctrl[r_wr_ptr]  <= f_decode(i_in_instr);
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Serialiser state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue gating and next state; a trap-class entry leaving the head blocks issue until flush.
    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_out_valid = (r_count != '0);
                if (w_out_valid && i_out_ready && w_head_trap) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HOLD: begin
                w_out_valid = 1'b0;
                w_state_nxt = ST_HOLD;
            end
            default: begin
                w_out_valid = 1'b0;
                w_state_nxt = ST_RUN;
            end
        endcase
        if (i_flush) begin
            w_state_nxt = ST_RUN;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    assign o_out_valid = w_out_valid;
    assign o_out_pc    = w_out_valid ? r_mem_pc[r_rd_ptr]    : {PC_W{1'b0}};
    assign o_out_instr = w_out_valid ? r_mem_instr[r_rd_ptr] : 32'd0;
    assign o_out_ctrl  = w_out_valid ? w_head_ctrl           : 21'd0;

endmodule
